// File: rtl/vpu_uart_pkg.sv
// Shared definitions for the UART instruction-memory loader/dumper pair.
//   UART_FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
//   dump_state_t    : dumper FSM state encoding
//   bytes_per_word  : number of UART bytes carried by one instruction word
package vpu_uart_pkg;

    localparam int unsigned UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        TX   = 3'd3,
        TXW  = 3'd4,
        FIN  = 3'd5
    } dump_state_t;

    function automatic int unsigned bytes_per_word(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter.
//   clk, rst  : clock, synchronous active-high reset
//   tx_start  : load tx_data and start a frame (accepted only while tx_busy=0)
//   tx_data   : byte to send, LSB first
//   tx_busy   : high for the full frame, starting the cycle after tx_start
//   tx        : serial line, idle high
module uart_tx_byte
    import vpu_uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 54
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx
);

    localparam int unsigned   CW       = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [3:0]    BIT_LAST = 4'(UART_FRAME_BITS - 1);

    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    sh;      // remaining data bits with the stop bit parked on top

    // Bit-period counter and frame sequencer; bit_idx 0 = start, 1..8 = data, 9 = stop
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_busy <= 1'b0;
            tx      <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '1;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_busy <= 1'b1;
                tx      <= 1'b0;
                cnt     <= '0;
                bit_idx <= '0;
                sh      <= {1'b1, tx_data};
            end
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == BIT_LAST) begin
                tx_busy <= 1'b0;
                tx      <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                tx      <= sh[0];
                sh      <= {1'b1, sh[8:1]};
            end
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_instr_mem_dumper.sv
// UART read-back engine for the instruction memory.
// Walks num_words addresses from start_addr (wrapping modulo DEPTH) through the
// synchronous read port and sends each word little-endian over 8N1 UART.
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle dump request, dropped unless idle
//   start_addr   : first word address (sampled on accepted start)
//   num_words    : word count 0..DEPTH (sampled on accepted start)
//   mem_rd_addr  : memory read address, changes only on entry to RD
//   mem_rd_data  : read data, valid one cycle after mem_rd_addr
//   uart_tx      : serial output, idle high
//   busy         : dump in progress
//   done         : one-cycle completion pulse
module uart_instr_mem_dumper
    import vpu_uart_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned CLK_PER_BIT = 54
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(DEPTH)-1:0] start_addr,
    input  logic [$clog2(DEPTH):0]   num_words,
    output logic [$clog2(DEPTH)-1:0] mem_rd_addr,
    input  logic [INSTR_WIDTH-1:0]   mem_rd_data,
    output logic                     uart_tx,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned NW  = AW + 1;
    localparam int unsigned BPW = bytes_per_word(INSTR_WIDTH);
    localparam int unsigned BIW = (BPW > 1) ? $clog2(BPW) : 1;

    dump_state_t          state;
    dump_state_t          state_next;
    logic [NW-1:0]        words_left;
    logic [BIW-1:0]       byte_idx;
    logic [INSTR_WIDTH-1:0] word_q;

    logic                 tx_busy;
    logic                 tx_start_c;
    logic [7:0]           tx_data_c;
    logic                 busy_d;
    logic                 done_d;
    logic                 last_byte_c;
    logic                 last_word_c;

    assign last_byte_c = (byte_idx == BIW'(BPW - 1));
    assign last_word_c = (words_left == NW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_words == '0) ? FIN : RD;
                end
            end
            RD:  state_next = CAP;
            CAP: state_next = TX;
            TX:  state_next = TXW;
            TXW: begin
                if (!tx_busy) begin
                    if (!last_byte_c) begin
                        state_next = TX;
                    end else if (last_word_c) begin
                        state_next = FIN;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; busy/done are decoded from the next state so the registered
    // copies line up with the state they describe
    always_comb begin
        tx_start_c = (state == TX);
        tx_data_c  = word_q[{byte_idx, 3'b000} +: 8];
        busy_d     = state_next inside {RD, CAP, TX, TXW};
        done_d     = (state_next == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Datapath: mem_rd_addr doubles as the walking address and only moves on entry to RD
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_addr <= '0;
            words_left  <= '0;
            byte_idx    <= '0;
            word_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        words_left <= num_words;
                        if (num_words != '0) begin
                            mem_rd_addr <= start_addr;
                        end
                    end
                end
                CAP: begin
                    word_q   <= mem_rd_data;
                    byte_idx <= '0;
                end
                TXW: begin
                    if (!tx_busy) begin
                        if (!last_byte_c) begin
                            byte_idx <= byte_idx + BIW'(1);
                        end else begin
                            words_left <= words_left - NW'(1);
                            if (!last_word_c) begin
                                mem_rd_addr <= mem_rd_addr + AW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    uart_tx_byte #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start_c),
        .tx_data  (tx_data_c),
        .tx_busy  (tx_busy),
        .tx       (uart_tx)
    );

endmodule
